// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: pointer sizing and read-mode selectors.
package fifo_pkg;

  localparam int MODE_REG  = 0;
  localparam int MODE_FWFT = 1;

  // One extra pointer bit distinguishes full from empty when the low bits match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x D_WIDTH storage with one write port and one registered read port.
module sync_fifo_ram #(
  parameter int DEPTH   = 8,
  parameter int D_WIDTH = 8,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the read register is cleared; array contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointers, occupancy count, status/sticky flags and the read output stage.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int D_WIDTH  = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = MODE_REG
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 w_en,
  input  logic [D_WIDTH-1:0]   wr_data,
  input  logic                 r_en,
  input  logic                 err_clr,
  output logic [D_WIDTH-1:0]   rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] ONE     = PW'(1);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  // Handshake: w_en and r_en are requests sampled on the rising edge. A write
  // is taken when not full, or when full and paired with a taken read; a read
  // is taken when not empty. A refused request sets overflow/underflow.
  // rd_valid qualifies rd_data: registered mode pulses it one cycle after a
  // taken read; FWFT mode holds it while the FIFO is non-empty, with r_en
  // acknowledging the presented head word.
  logic [PW-1:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count_q;
  logic               wr_acc, rd_acc;
  logic               ram_rd_en;
  logic [AW-1:0]      ram_rd_addr;
  logic [D_WIDTH-1:0] ram_q;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  assign rd_acc = reset_n && r_en && !empty;
  assign wr_acc = reset_n && w_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    if (wr_acc) wr_ptr_n = wr_ptr + ONE;
    if (rd_acc) rd_ptr_n = rd_ptr + ONE;
  end

  // count is registered from the next pointers, so it always equals their modular difference.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      count_q <= wr_ptr_n - rd_ptr_n;
      if (w_en && !wr_acc) overflow <= 1'b1;
      else if (err_clr)    overflow <= 1'b0;
      if (r_en && !rd_acc) underflow <= 1'b1;
      else if (err_clr)    underflow <= 1'b0;
    end
  end

  sync_fifo_ram #(
    .DEPTH   (DEPTH),
    .D_WIDTH (D_WIDTH),
    .AW      (AW)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_q)
  );

  if (FWFT == MODE_FWFT) begin : g_fwft
    logic               bypass_sel;
    logic [D_WIDTH-1:0] bypass_q;

    // The RAM prefetches the next head. A write landing on that address only
    // happens when it becomes the sole entry, and the RAM would return stale
    // data for it, so the written word is forwarded instead.
    assign ram_rd_en   = 1'b1;
    assign ram_rd_addr = rd_ptr_n[AW-1:0];

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        bypass_sel <= 1'b0;
        bypass_q   <= '0;
      end else begin
        bypass_sel <= wr_acc && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0]);
        if (wr_acc) bypass_q <= wr_data;
      end
    end

    assign rd_data  = bypass_sel ? bypass_q : ram_q;
    assign rd_valid = !empty;
  end else begin : g_reg
    logic reg_valid;

    assign ram_rd_en   = rd_acc;
    assign ram_rd_addr = rd_ptr[AW-1:0];

    always_ff @(posedge clk) begin
      if (!reset_n) reg_valid <= 1'b0;
      else          reg_valid <= rd_acc;
    end

    assign rd_data  = ram_q;
    assign rd_valid = reg_valid;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: registered-read instance with a scoreboard, plus an FWFT instance.
module tb_sync_fifo;

  logic       clk;
  logic       reset_n;
  logic       w_en, r_en, err_clr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  logic       fw_w_en, fw_r_en, fw_err_clr;
  logic [7:0] fw_wr_data;
  logic [7:0] f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [3:0] f_count;

  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;
  int         total;
  int         bad;
  int         m_count;
  logic       m_ovf, m_udf;

  sync_fifo u_reg (
    .clk(clk), .reset_n(reset_n), .w_en(w_en), .wr_data(wr_data), .r_en(r_en),
    .err_clr(err_clr), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo #(.FWFT(1)) u_fwft (
    .clk(clk), .reset_n(reset_n), .w_en(fw_w_en), .wr_data(fw_wr_data), .r_en(fw_r_en),
    .err_clr(fw_err_clr), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
    .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
    .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every registered-mode output word is checked against write order
  always @(negedge clk) begin
    if (rd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: rd_valid=1 rd_data=%0d, expected no output", rd_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (rd_data !== sb_exp) begin
          bad++;
          $display("FAIL sb_data: got %0d want %0d", rd_data, sb_exp);
        end
      end
    end
  end

  // driver for the registered instance, with a reference model of acceptance
  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic wa, ra;
    @(negedge clk);
    w_en = w; wr_data = d; r_en = r; err_clr = c;
    ra = r && (m_count != 0);
    wa = w && ((m_count != 8) || ra);
    if (wa) exp_q.push_back(d);
    if (w && !wa) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && !ra) m_udf = 1'b1; else if (c) m_udf = 1'b0;
    m_count = m_count + int'(wa) - int'(ra);
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic drive_fw(input logic w, input logic [7:0] d, input logic r);
    @(negedge clk);
    fw_w_en = w; fw_wr_data = d; fw_r_en = r;
    @(posedge clk); #1;
    fw_w_en = 1'b0; fw_r_en = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_count = 0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: count=%0d empty=%b full=%b ae=%b af=%b, want 0 1 0 1 0",
               count, empty, full, almost_empty, almost_full);
    end
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 8'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: rd_valid=%b rd_data=%0d ovf=%b udf=%b, want 0 0 0 0",
               rd_valid, rd_data, overflow, underflow);
    end
    total++;
    if (f_rd_valid !== 1'b0 || f_rd_data !== 8'd0 || f_count !== 4'd0) begin
      bad++;
      $display("FAIL reset_fwft: rd_valid=%b rd_data=%0d count=%0d, want 0 0 0", f_rd_valid, f_rd_data, f_count);
    end
    reset_n = 1'b1;
    clear_model();
  endtask

  task automatic test_fill();
    logic [7:0] vals [5];
    vals = '{8'd45, 8'd23, 8'd27, 8'd22, 8'd12};
    for (int i = 0; i < 5; i++) drive(1'b1, vals[i], 1'b0, 1'b0);
    total++;
    if (count !== 4'd5 || almost_full !== 1'b0 || almost_empty !== 1'b0 || empty !== 1'b0) begin
      bad++;
      $display("FAIL fill: count=%0d af=%b ae=%b empty=%b, want 5 0 0 0", count, almost_full, almost_empty, empty);
    end
  endtask

  task automatic test_drain();
    logic [7:0] vals [5];
    vals = '{8'd45, 8'd23, 8'd27, 8'd22, 8'd12};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== vals[i]) begin
        bad++;
        $display("FAIL drain_%0d: rd_valid=%b rd_data=%0d, want 1 %0d", i, rd_valid, rd_data, vals[i]);
      end
    end
    total++;
    if (empty !== 1'b1 || count !== 4'd0 || almost_empty !== 1'b1) begin
      bad++;
      $display("FAIL drain_end: empty=%b count=%0d ae=%b, want 1 0 1", empty, count, almost_empty);
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 8'd12) begin
      bad++;
      $display("FAIL drain_hold: rd_valid=%b rd_data=%0d, want 0 12", rd_valid, rd_data);
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    total++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 4'd0) begin
      bad++;
      $display("FAIL underflow_set: udf=%b rd_valid=%b count=%0d, want 1 0 0", underflow, rd_valid, count);
    end
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    total++;
    if (underflow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_clr: udf=%b want 0", underflow);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      if (i == 7) begin
        total++;
        if (full !== 1'b1 || almost_full !== 1'b1 || overflow !== 1'b0 || count !== 4'd8) begin
          bad++;
          $display("FAIL ovf_full: full=%b af=%b ovf=%b count=%0d, want 1 1 0 8", full, almost_full, overflow, count);
        end
      end
    end
    total++;
    if (overflow !== 1'b1 || count !== 4'd8 || exp_q.size() != 8) begin
      bad++;
      $display("FAIL ovf_drop: ovf=%b count=%0d, want 1 8", overflow, count);
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set_priority: ovf=%b want 1", overflow);
    end
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    total++;
    if (overflow !== m_ovf || overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr: ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] oldest;
    oldest = exp_q[0];
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    total++;
    if (count !== 4'd8 || full !== 1'b1 || rd_valid !== 1'b1 || rd_data !== oldest || overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_rw: count=%0d full=%b rd_valid=%b rd_data=%0d ovf=%b, want 8 1 1 %0d 0",
               count, full, rd_valid, rd_data, oldest, overflow);
    end
    for (int i = 0; i < 8; i++) drive(1'b0, 8'd0, 1'b1, 1'b0);
    total++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      bad++;
      $display("FAIL full_rw_drain: empty=%b count=%0d, want 1 0", empty, count);
    end
  endtask

  task automatic test_fwft_empty_rw();
    logic [7:0] vals [4];
    vals = '{8'd14, 8'd101, 8'd102, 8'd103};
    drive_fw(1'b1, 8'd14, 1'b1);
    total++;
    if (f_underflow !== 1'b1 || f_count !== 4'd1 || f_rd_valid !== 1'b1 || f_rd_data !== 8'd14) begin
      bad++;
      $display("FAIL fwft_empty_rw: udf=%b count=%0d rd_valid=%b rd_data=%0d, want 1 1 1 14",
               f_underflow, f_count, f_rd_valid, f_rd_data);
    end
    for (int i = 1; i < 4; i++) drive_fw(1'b1, vals[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (f_rd_valid !== 1'b1 || f_rd_data !== vals[i]) begin
        bad++;
        $display("FAIL fwft_head_%0d: rd_valid=%b rd_data=%0d, want 1 %0d", i, f_rd_valid, f_rd_data, vals[i]);
      end
      drive_fw(1'b0, 8'd0, 1'b1);
    end
    total++;
    if (f_rd_valid !== 1'b0 || f_empty !== 1'b1 || f_count !== 4'd0) begin
      bad++;
      $display("FAIL fwft_drain: rd_valid=%b empty=%b count=%0d, want 0 1 0", f_rd_valid, f_empty, f_count);
    end
  endtask

  task automatic test_wrap_and_reset();
    int op;
    for (int i = 0; i < 20; i++) begin
      op = $urandom_range(0, 3);
      drive(op != 1, 8'($urandom_range(0, 255)), op == 1 || op == 2, 1'b0);
      total++;
      if (count !== 4'(m_count) || overflow !== m_ovf || underflow !== m_udf) begin
        bad++;
        $display("FAIL wrap_step_%0d: count=%0d ovf=%b udf=%b, want %0d %b %b",
                 i, count, overflow, underflow, m_count, m_ovf, m_udf);
      end
    end
    for (int i = 0; i < 16 && m_count > 3; i++) drive(1'b0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 16 && m_count < 3; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    total++;
    if (count !== 4'd3) begin
      bad++;
      $display("FAIL wrap_pre_reset: count=%0d want 3", count);
    end
    @(negedge clk);
    reset_n = 1'b0; w_en = 1'b1; r_en = 1'b1; wr_data = 8'd99;
    @(posedge clk); #1;
    reset_n = 1'b1; w_en = 1'b0; r_en = 1'b0;
    clear_model();
    total++;
    if (count !== 4'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: count=%0d empty=%b rd_valid=%b, want 0 1 0", count, empty, rd_valid);
    end
    drive(1'b1, 8'd77, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 8'd77 || empty !== 1'b1) begin
      bad++;
      $display("FAIL post_reset: rd_valid=%b rd_data=%0d empty=%b, want 1 77 1", rd_valid, rd_data, empty);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; wr_data = 8'd0;
    fw_w_en = 1'b0; fw_r_en = 1'b0; fw_err_clr = 1'b0; fw_wr_data = 8'd0;
    clear_model();
    test_reset();
    test_fill();
    test_drain();
    test_underflow();
    test_overflow();
    test_full_rw();
    test_fwft_empty_rw();
    test_wrap_and_reset();
    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d expected words never read, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of entries; legal values are powers of two, 2 or more.
REQ-002 The block SHALL have parameter D_WIDTH, default 8, giving the data word width.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, giving the almost_full threshold in entries.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, giving the almost_empty threshold in entries.
REQ-005 The block SHALL have parameter FWFT, default 0, selecting the read mode: 0 is registered read, 1 is first-word-fall-through.
REQ-006 The ports SHALL be:
- clk  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- w_en  in  1  write request.
- wr_data  in  D_WIDTH  write data.
- r_en  in  1  read request.
- err_clr  in  1  clears the sticky error flags.
- rd_data  out  D_WIDTH  read data.
- rd_valid  out  1  rd_data is valid.
- full  out  1  count = DEPTH.
- empty  out  1  count = 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  log2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: a write was dropped.
- underflow  out  1  sticky flag: a read was rejected.

Function
REQ-007 A write SHALL be accepted when w_en=1 and either full=0, or full=1 with an accepted read in the same cycle.
REQ-008 A read SHALL be accepted when r_en=1 and empty=0.
REQ-009 Write and read pointers SHALL be log2(DEPTH)+1 bits wide, wrap modulo 2*DEPTH, and index memory with their low log2(DEPTH) bits.
REQ-010 count SHALL equal wr_ptr minus rd_ptr, modulo 2*DEPTH.
REQ-011 count SHALL change as follows: +1 for a write alone, -1 for a read alone, no change for a simultaneous accepted write and read.
REQ-012 All status flags SHALL be derived from the count register, so they are valid in the cycle after the edge that updates count.
REQ-013 In FWFT=0 mode, an accepted read SHALL drive the head word onto rd_data and set rd_valid=1 one cycle later.
REQ-014 In FWFT=0 mode, rd_valid=0 SHALL hold otherwise, and rd_data SHALL hold its last value.
REQ-015 In FWFT=1 mode, rd_valid SHALL equal not-empty, rd_data SHALL present the head word whenever rd_valid=1, and r_en SHALL pop that word.
REQ-016 In FWFT=1 mode, after a write into an empty FIFO, rd_valid SHALL be 1 in the cycle following the write edge.
REQ-017 A write attempted with full=1 and no accepted read SHALL be dropped, leave memory and pointers unchanged, and set overflow.
REQ-018 A read attempted with empty=1 SHALL be rejected and set underflow.
REQ-019 When empty=1 and w_en=r_en=1, the write SHALL be accepted, the read rejected, underflow set, and count SHALL become 1.
REQ-020 overflow and underflow SHALL clear on err_clr=1.
REQ-021 If err_clr=1 coincides with a new error event, the flag SHALL be set, so the set takes priority.
REQ-022 Data SHALL be returned in write order across pointer wrap-around, with no loss or duplication.

Reset
REQ-023 When reset_n=0 at a clk edge, the block SHALL set pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0, rd_data=0, overflow=0 and underflow=0.
REQ-024 Reset asserted mid-operation SHALL discard all stored entries, with w_en and r_en ignored while reset_n=0.
REQ-025 Memory contents SHALL NOT be reset.

Structure
REQ-026 A shared package fifo_pkg SHALL hold the clog2-based pointer width function and the read-mode constants MODE_REG=0 and MODE_FWFT=1.
REQ-027 Storage SHALL be one sub-module, sync_fifo_ram: DEPTH x D_WIDTH, one write port, one read port, registered read.
REQ-028 Pointers, count, flags and the FWFT output stage SHALL reside in sync_fifo.

Verification
REQ-029 Scenario, reset and fill: with DEPTH=8 and FWFT=0, write 45, 23, 27, 22, 12 -> count=5, almost_full=0, almost_empty=0.
REQ-030 Scenario, drain: read 5 times -> rd_data returns 45, 23, 27, 22, 12, each one cycle after its r_en; then empty=1, count=0.
REQ-031 Scenario, overflow and clear: write 9 words into 8 entries -> full=1 after the 8th, the 9th is dropped, overflow=1; err_clr pulse -> overflow=0.
REQ-032 Scenario, full with simultaneous write and read: w_en=r_en=1 while full -> both accepted, count stays 8, the oldest word is read.
REQ-033 Scenario, empty with simultaneous write and read, FWFT=1: w_en=r_en=1 with wr_data=14 -> underflow=1, count=1; next cycle rd_valid=1 and rd_data=14.
REQ-034 Scenario, wrap and mid-run reset: 20 interleaved writes and reads checked in order against a scoreboard, then reset_n=0 for one cycle with count=3 -> count=0, empty=1, rd_valid=0.
